// File: rtl/pe_disp_pkg.sv
// Shared constants for the priority encoder hex display.
// Hex-to-segment table (gfedcba), blank pattern, clog2 helper.
package pe_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder: highest set bit wins.
// Scans low to high so the last set bit seen is the result.
module prio_enc #(
  parameter int WIDTH = 32,
  parameter int IW    = 5
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder_hex_display.sv
// Registered priority encoder with live/peak-hold result and a
// time-multiplexed hex 7-segment display.
module priority_encoder_hex_display
  import pe_disp_pkg::*;
#(
  parameter int  WIDTH          = 32,
  parameter int  SCAN_DIV       = 1024,
  parameter bit  SEG_ACTIVE_LOW = 1'b0,
  localparam int IW   = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1,
  localparam int NDIG = (IW + 3) / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             hold,
  input  logic             clear,
  output logic [IW-1:0]    index,
  output logic             valid,
  output logic [6:0]       segments,
  output logic             dp,
  output logic [NDIG-1:0]  digit_en
);

  localparam int PW = (NDIG > 1) ? clog2(NDIG) : 1;
  localparam int XW = 4 * NDIG;
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [WIDTH-1:0] r_data_q;
  logic [IW-1:0]    r_index;
  logic             r_valid;
  logic [15:0]      r_cnt;
  logic [PW-1:0]    r_ptr;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [NDIG-1:0]  r_dig;

  logic [IW-1:0]    w_enc_idx;
  logic             w_enc_any;
  logic [IW-1:0]    w_nxt_idx;
  logic             w_nxt_vld;
  logic [XW-1:0]    w_index_x;
  logic [3:0]       w_nib;
  logic [NDIG-1:0]  w_dig;
  logic             w_ptr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data_q <= '0;
    else     r_data_q <= data;
  end

  prio_enc #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_enc (
    .i_data (r_data_q),
    .o_idx  (w_enc_idx),
    .o_any  (w_enc_any)
  );

  always_comb begin
    w_nxt_idx = r_index;
    w_nxt_vld = r_valid;
    if (clear) begin
      w_nxt_idx = '0;
      w_nxt_vld = 1'b0;
    end else if (hold) begin
      w_nxt_idx = r_index;
    end else if (!mode) begin
      w_nxt_idx = w_enc_any ? w_enc_idx : '0;
      w_nxt_vld = w_enc_any;
    end else if (w_enc_any &&
                 (!r_valid || w_enc_idx > r_index)) begin
      w_nxt_idx = w_enc_idx;
      w_nxt_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index <= '0;
      r_valid <= 1'b0;
    end else begin
      r_index <= w_nxt_idx;
      r_valid <= w_nxt_vld;
    end
  end

  assign w_ptr_last = (r_ptr == PW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ptr <= '0;
    end else if (r_cnt == SCAN_LAST) begin
      r_cnt <= '0;
      r_ptr <= w_ptr_last ? '0 : r_ptr + PW'(1);
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Zero-pad the index so the top nibble shows unused bits as 0.
  assign w_index_x = XW'(r_index);

  always_comb begin
    w_nib = '0;
    w_dig = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (r_ptr == PW'(d)) begin
        w_nib    = w_index_x[4*d +: 4];
        w_dig[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig <= NDIG'(1);
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_dig <= w_dig;
      r_seg <= r_valid ? HEX_SEG[w_nib] : SEG_OFF;
      r_dp  <= !r_valid && (r_ptr == '0);
    end
  end

  assign index    = r_index;
  assign valid    = r_valid;
  assign segments = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign dp       = SEG_ACTIVE_LOW ? ~r_dp  : r_dp;
  assign digit_en = SEG_ACTIVE_LOW ? ~r_dig : r_dig;

endmodule

// File: tb/tb_priority_encoder_hex_display.sv
// Scoreboard bench for priority_encoder_hex_display.
// Reference model pushes expected outputs; monitor pops on negedge.
module tb_priority_encoder_hex_display;

  localparam int WIDTH = 32;
  localparam int SCAN_DIV = 4;
  localparam int NDIG = 2;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        mode;
  logic        hold;
  logic        clear;
  logic [4:0]  index;
  logic        valid;
  logic [6:0]  segments;
  logic        dp;
  logic [1:0]  digit_en;

  int n_tests;
  int n_fail;

  typedef struct {
    int idx;
    int vld;
    int seg;
    int dp;
    int dig;
  } exp_t;

  exp_t q[$];

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  priority_encoder_hex_display #(
    .WIDTH          (WIDTH),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .mode     (mode),
    .hold     (hold),
    .clear    (clear),
    .index    (index),
    .valid    (valid),
    .segments (segments),
    .dp       (dp),
    .digit_en (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int msb(input logic [31:0] d);
    logic [31:0] x;
    int k;
    x = d;
    k = 0;
    while (x > 1) begin
      x = x >> 1;
      k++;
    end
    return k;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset give the digit by division.
  initial begin : model
    logic [31:0] m_dq;
    int m_idx;
    int m_vld;
    int m_n;
    int p;
    int top;
    bit any;
    exp_t e;
    m_dq = 0; m_idx = 0; m_vld = 0; m_n = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_dq = 0; m_idx = 0; m_vld = 0; m_n = 0;
        q.delete();
      end else begin
        p = (m_n / SCAN_DIV) % NDIG;
        e.dig = 1 << p;
        e.seg = m_vld ? int'(hex_tab[(m_idx >> (4*p)) & 15]) : 0;
        e.dp  = (m_vld == 0 && p == 0) ? 1 : 0;
        any = (m_dq != 0);
        top = msb(m_dq);
        if (clear) begin
          m_idx = 0; m_vld = 0;
        end else if (hold) begin
          m_idx = m_idx;
        end else if (!mode) begin
          m_idx = any ? top : 0;
          m_vld = any ? 1 : 0;
        end else if (any && (m_vld == 0 || top > m_idx)) begin
          m_idx = top; m_vld = 1;
        end
        m_dq = data;
        m_n++;
        e.idx = m_idx;
        e.vld = m_vld;
        q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front();
      else e = '{idx: 0, vld: 0, seg: 0, dp: 1, dig: 1};
      chk("index", int'(index), e.idx);
      chk("valid", int'(valid), e.vld);
      chk("segments", int'(segments), e.seg);
      chk("dp", int'(dp), e.dp);
      chk("digit_en", int'(digit_en), e.dig);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_data();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: return 32'h0;
      1: return 32'h1 << $urandom_range(0, 31);
      2: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    data = '0; mode = 0; hold = 0; clear = 0;
    #13 rst = 1'b0;

    step(20);

    data = 32'h0000_0900;
    step(2);
    chk("live_idx_B", int'(index), 11);
    chk("live_vld_B", int'(valid), 1);
    step(6);

    data = 32'h8000_0001;
    step(2);
    chk("live_idx_31", int'(index), 31);
    data = 32'h0000_0001;
    step(2);
    chk("live_idx_0", int'(index), 0);
    chk("live_vld_0", int'(valid), 1);
    step(8);

    mode = 1; data = 32'h10;
    step(1); data = 32'h400;
    step(1); data = 32'h2;
    step(1);
    chk("peak_10", int'(index), 10);
    step(2);
    chk("peak_keep", int'(index), 10);
    clear = 1;
    step(1);
    clear = 0;
    chk("peak_clr_idx", int'(index), 0);
    chk("peak_clr_vld", int'(valid), 0);
    step(1);
    chk("peak_after_clr", int'(index), 1);

    mode = 0; data = 32'h4;
    step(2);
    chk("hold_pre", int'(index), 2);
    hold = 1; data = 32'h100;
    step(3);
    chk("hold_idx", int'(index), 2);
    clear = 1;
    step(1);
    clear = 0;
    chk("hold_clr_vld", int'(valid), 0);
    hold = 0;
    step(1);
    chk("unhold_idx", int'(index), 8);
    chk("unhold_vld", int'(valid), 1);

    step(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", int'(index), 0);
    chk("arst_vld", int'(valid), 0);
    chk("arst_dig", int'(digit_en), 1);
    chk("arst_dp", int'(dp), 1);
    #3 rst = 1'b0;
    step(1);
    chk("rec_vld0", int'(valid), 0);
    step(1);
    chk("rec_idx", int'(index), 8);
    chk("rec_vld1", int'(valid), 1);

    for (int c = 0; c < 3000; c++) begin
      data = rnd_data();
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 15) == 0);
      if (c == 1500) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
      end
      step(1);
    end

    hold = 0; clear = 0;
    step(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
